ram_arbiter_2x: RTL

RAM_ARBITER_2X -- requirements
Module: ram_arbiter_2x

---
 rtl/ram_arbiter_2x.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_arbiter_2x.sv
// ram_arbiter_2x: two-requester arbiter for a single-port RAM.
// Each access takes one ACCESS cycle. The RAM commits writes on the falling
// clock edge and its read data is combinational.
// Build option: define RAM_ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// round-robin. Without it, requester 0 always wins.
module ram_arbiter_2x #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t            state, state_nxt;
   logic              owner, owner_nxt;
   logic              ack0_nxt, ack1_nxt;
   logic              ram_we_nxt, busy_nxt;
   logic [ADDR_W-1:0] ram_addr_nxt;
   logic [DATA_W-1:0] ram_din_nxt;
   logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;
   logic              elig0, elig1, grant_any, grant1;

   // A requester is not eligible while its ack is showing, so a held request is not served twice
   assign elig0     = req0 & ~ack0;
   assign elig1     = req1 & ~ack1;
   assign grant_any = elig0 | elig1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic rr_ptr;

   // rr_ptr = 1 favours requester 1. The last winner gets lowest priority.
   assign grant1 = elig1 & (~elig0 | rr_ptr);

   // Point the round-robin pointer at the requester that did not win
   always_ff @(posedge clk) begin
      if (reset)
         rr_ptr <= 1'b0;
      else if ((state == IDLE) && grant_any)
         rr_ptr <= ~grant1;
   end
`else
   // Fixed priority: requester 1 wins only when requester 0 is not eligible
   assign grant1 = elig1 & ~elig0;
`endif

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         ram_we   <= 1'b0;
         busy     <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         rdata0   <= '0;
         rdata1   <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         ack0     <= ack0_nxt;
         ack1     <= ack1_nxt;
         ram_we   <= ram_we_nxt;
         busy     <= busy_nxt;
         ram_addr <= ram_addr_nxt;
         ram_din  <= ram_din_nxt;
         rdata0   <= rdata0_nxt;
         rdata1   <= rdata1_nxt;
      end
   end

   // Next state: grant in IDLE, then complete the access in ACCESS
   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      ack0_nxt     = 1'b0;
      ack1_nxt     = 1'b0;
      ram_we_nxt   = 1'b0;
      busy_nxt     = 1'b0;
      ram_addr_nxt = ram_addr;
      ram_din_nxt  = ram_din;
      rdata0_nxt   = rdata0;
      rdata1_nxt   = rdata1;
      case (state)
         IDLE: begin
            if (grant_any) begin
               state_nxt    = ACCESS;
               busy_nxt     = 1'b1;
               owner_nxt    = grant1;
               ram_we_nxt   = grant1 ? we1    : we0;
               ram_addr_nxt = grant1 ? addr1  : addr0;
               ram_din_nxt  = grant1 ? wdata1 : wdata0;
            end
         end
         ACCESS: begin
            state_nxt = IDLE;
            if (owner) begin
               ack1_nxt = 1'b1;
               if (!ram_we) rdata1_nxt = ram_dout;
            end else begin
               ack0_nxt = 1'b1;
               if (!ram_we) rdata0_nxt = ram_dout;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
